// File: rtl/nanov_mmio_pkg.sv
// Shared register map, status bit positions and drain FSM encoding for the nanoV MMIO peripheral.
package nanov_mmio_pkg;

  localparam logic [31:0] UART_OFS  = 32'h0000_1000;
  localparam logic [11:0] OFS_GPIO  = 12'h000;
  localparam logic [11:0] OFS_UDATA = 12'h000;
  localparam logic [11:0] OFS_USTAT = 12'h004;

  localparam int unsigned STAT_TX_FULL = 0;
  localparam int unsigned STAT_RX_NE   = 1;
  localparam int unsigned STAT_RX_OVF  = 2;
  localparam int unsigned STAT_TX_DROP = 3;
  localparam int unsigned STAT_TX_IDLE = 4;
  localparam int unsigned STAT_RX_LVL  = 8;
  localparam int unsigned STAT_TX_LVL  = 16;

  typedef enum logic [1:0] {
    DRN_IDLE  = 2'd0,
    DRN_START = 2'd1,
    DRN_WAITB = 2'd2,
    DRN_WAITI = 2'd3
  } drain_state_e;

  // The CPU drives store data MSB-first on data_out
  function automatic logic [31:0] bit_rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

endpackage

// File: rtl/nanov_mmio_periph_if.sv
// nanoV CPU bus as seen by a memory-mapped peripheral.
interface nanov_mmio_periph_if;
  logic [31:0] data_out;
  logic        is_addr;
  logic        is_data;
  logic        is_store;
  logic [31:0] data_in;

  modport master (output data_out, is_addr, is_data, is_store, input data_in);
  modport slave  (input data_out, is_addr, is_data, is_store, output data_in);
endinterface

// File: rtl/nanov_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is combinational, simultaneous push+pop allowed when full.
module nanov_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH) + 1
) (
  input  logic             cpu_clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1] != rptr[AW-1]) && (wptr[AW-2:0] == rptr[AW-2:0]);
  assign level   = wptr - rptr;
  assign dout    = mem[rptr[AW-2:0]];
  // A pop on empty is ignored; a push on full lands only if a pop frees the slot
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (do_push) mem[wptr[AW-2:0]] <= din;
  end

endmodule

// File: rtl/nanov_mmio_periph.sv
// GPIO register plus FIFO-buffered UART TX/RX behind the nanoV CPU bus.
module nanov_mmio_periph
  import nanov_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned GPIO_OUT_W = 32,
  parameter int unsigned GPIO_IN_W  = 3,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8
) (
  input  logic                  cpu_clk,
  input  logic                  rstn,
  nanov_mmio_periph_if.slave    bus,
  output logic [GPIO_OUT_W-1:0] gpio_out,
  input  logic [GPIO_IN_W-1:0]  gpio_in,
  output logic                  uart_tx_en,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_tx_busy,
  input  logic                  uart_rx_valid,
  input  logic [7:0]            uart_rx_data,
  output logic                  uart_rx_read
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH) + 1;
  localparam logic [31:0] GPIO_ADDR  = BASE_ADDR + 32'(OFS_GPIO);
  localparam logic [31:0] UDATA_ADDR = BASE_ADDR + UART_OFS + 32'(OFS_UDATA);
  localparam logic [31:0] USTAT_ADDR = BASE_ADDR + UART_OFS + 32'(OFS_USTAT);

  logic sel_gpio, sel_data, sel_stat;
  logic rx_ovf, tx_drop;
  logic [31:0] wdata, status;
  logic wr, rd, stat_wr;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic [TX_AW-1:0] tx_level;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic [RX_AW-1:0] rx_level;
  logic tx_idle;

  drain_state_e state, state_next;

  assign wdata   = bit_rev32(bus.data_out);
  assign wr      = bus.is_data && bus.is_store;
  assign rd      = bus.is_data && !bus.is_store;
  assign stat_wr = wr && sel_stat;
  assign tx_push = wr && sel_data;
  assign rx_pop  = rd && sel_data && !rx_empty;
  // read_q guard: the cycle uart_rx_read is high the source is still dropping valid
  assign rx_push = uart_rx_valid && !uart_rx_read;
  assign tx_idle = tx_empty && (state == DRN_IDLE) && !uart_tx_busy;

  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      sel_gpio <= 1'b0;
      sel_data <= 1'b0;
      sel_stat <= 1'b0;
    end else if (bus.is_addr) begin
      sel_gpio <= (bus.data_out == GPIO_ADDR);
      sel_data <= (bus.data_out == UDATA_ADDR);
      sel_stat <= (bus.data_out == USTAT_ADDR);
    end
  end

  // GPIO, sticky flags (set beats clear) and the RX acknowledge pulse
  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      gpio_out     <= '0;
      rx_ovf       <= 1'b0;
      tx_drop      <= 1'b0;
      uart_rx_read <= 1'b0;
    end else begin
      if (wr && sel_gpio) gpio_out <= wdata[GPIO_OUT_W-1:0];
      rx_ovf  <= (rx_push && rx_full && !rx_pop) ||
                 (rx_ovf && !(stat_wr && wdata[STAT_RX_OVF]));
      tx_drop <= (tx_push && tx_full && !tx_pop) ||
                 (tx_drop && !(stat_wr && wdata[STAT_TX_DROP]));
      uart_rx_read <= rx_push;
    end
  end

  nanov_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .cpu_clk (cpu_clk),
    .rstn    (rstn),
    .push    (tx_push),
    .pop     (tx_pop),
    .din     (wdata[7:0]),
    .dout    (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  nanov_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .cpu_clk (cpu_clk),
    .rstn    (rstn),
    .push    (rx_push),
    .pop     (rx_pop),
    .din     (uart_rx_data),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  always_ff @(posedge cpu_clk) begin
    if (!rstn) state <= DRN_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DRN_IDLE:  if (!tx_empty && !uart_tx_busy) state_next = DRN_START;
      DRN_START: state_next = DRN_WAITB;
      DRN_WAITB: if (uart_tx_busy) state_next = DRN_WAITI;
      DRN_WAITI: if (!uart_tx_busy) state_next = DRN_IDLE;
      default:   state_next = DRN_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = 1'b0;
    if (state == DRN_IDLE && !tx_empty && !uart_tx_busy) tx_pop = 1'b1;
  end

  // uart_tx_en is high exactly while the FSM sits in START
  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      uart_tx_en <= tx_pop;
      if (tx_pop) uart_tx_data <= tx_head;
    end
  end

  always_comb begin
    status               = '0;
    status[STAT_TX_FULL] = tx_full;
    status[STAT_RX_NE]   = !rx_empty;
    status[STAT_RX_OVF]  = rx_ovf;
    status[STAT_TX_DROP] = tx_drop;
    status[STAT_TX_IDLE] = tx_idle;
    status[STAT_RX_LVL +: 8] = 8'(rx_level);
    status[STAT_TX_LVL +: 8] = 8'(tx_level);
  end

  always_comb begin
    bus.data_in = '0;
    if (sel_gpio)                  bus.data_in = 32'(gpio_in);
    else if (sel_data && !rx_empty) bus.data_in = {24'h0, rx_head};
    else if (sel_stat)             bus.data_in = status;
  end

endmodule

// File: tb/tb_nanov_mmio_periph.sv
// Scoreboard bench: stimulus updates a queue-based model and posts expectations; a negedge monitor checks them.
module tb_nanov_mmio_periph;

  localparam int unsigned FRAME = 16;
  localparam int unsigned TXD   = 8;
  localparam int unsigned RXD   = 8;
  localparam logic [31:0] A_GPIO  = 32'h1000_0000;
  localparam logic [31:0] A_UDATA = 32'h1000_1000;
  localparam logic [31:0] A_USTAT = 32'h1000_1004;

  localparam int K_GPIO = 0, K_TXEN = 1, K_RXRD = 2, K_TXDATA = 3, K_PULSES = 4, K_TXLEFT = 5, K_TMO = 6;

  logic        cpu_clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] gpio_out;
  logic [2:0]  gpio_in;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_read;

  always #5 cpu_clk = ~cpu_clk;

  nanov_mmio_periph_if bus ();

  nanov_mmio_periph dut (
    .cpu_clk       (cpu_clk),
    .rstn          (rstn),
    .bus           (bus),
    .gpio_out      (gpio_out),
    .gpio_in       (gpio_in),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_read  (uart_rx_read)
  );

  // Behavioural uart_tx: busy for FRAME cycles after each start pulse, plus an external stall
  logic tx_stall;
  logic tx_frame_busy;
  int   tx_cnt;
  always @(posedge cpu_clk) begin
    if (!rstn) begin
      tx_frame_busy <= 1'b0;
      tx_cnt        <= 0;
    end else if (uart_tx_en) begin
      tx_frame_busy <= 1'b1;
      tx_cnt        <= FRAME;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_frame_busy <= 1'b0;
    end
  end
  assign uart_tx_busy = tx_frame_busy | tx_stall;

  typedef struct { int tag; logic [31:0] v; } rd_t;
  typedef struct { int kind; logic [31:0] exp; logic [31:0] aux; } chk_t;

  rd_t        exp_rd[$];
  chk_t       chks[$];
  logic [7:0] exp_tx[$];

  // Reference model state
  logic [7:0]  rxq[$];
  bit          m_ovf, m_drop, m_idle;
  int          m_txlvl;
  logic [31:0] m_gpio;
  int          exp_pulses;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_pulses = 0;

  function automatic string rd_name(input int t);
    case (t)
      0: return "rd_gpio";
      1: return "rd_data";
      2: return "rd_status";
      default: return "rd_unmapped";
    endcase
  endfunction

  function automatic string k_name(input int k);
    case (k)
      K_GPIO:   return "gpio_out";
      K_TXEN:   return "uart_tx_en";
      K_RXRD:   return "uart_rx_read";
      K_TXDATA: return "uart_tx_data";
      K_PULSES: return "rx_read_pulses";
      K_TXLEFT: return "tx_bytes_missing";
      default:  return "handshake_timeout";
    endcase
  endfunction

  function automatic logic [31:0] stat_word();
    bit rx_ne, tx_full;
    rx_ne   = (rxq.size() != 0);
    tx_full = (m_txlvl == int'(TXD));
    return {8'h00, 8'(m_txlvl), 8'(rxq.size()), 3'b000, m_idle, m_drop, m_ovf, rx_ne, tx_full};
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge cpu_clk) begin : monitor
    rd_t         e;
    chk_t        c;
    logic [31:0] got;
    if (bus.is_data && !bus.is_store) begin
      n_tests++;
      if (exp_rd.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h, required no read", bus.data_in);
      end else begin
        e = exp_rd.pop_front();
        if (bus.data_in !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h, required %h", rd_name(e.tag), bus.data_in, e.v);
        end
      end
    end
    if (uart_tx_en) begin
      n_tests++;
      if (exp_tx.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got byte %h, required no transmission", uart_tx_data);
      end else begin
        got = 32'(exp_tx.pop_front());
        if (32'(uart_tx_data) !== got) begin
          n_fail++;
          $display("FAIL tx_byte: got %h, required %h", uart_tx_data, got[7:0]);
        end
      end
    end
    if (uart_rx_read) rx_pulses++;
    while (chks.size() > 0) begin
      c = chks.pop_front();
      case (c.kind)
        K_GPIO:   got = gpio_out;
        K_TXEN:   got = 32'(uart_tx_en);
        K_RXRD:   got = 32'(uart_rx_read);
        K_TXDATA: got = 32'(uart_tx_data);
        K_PULSES: got = 32'(rx_pulses);
        K_TXLEFT: got = 32'(exp_tx.size());
        default:  got = c.aux;
      endcase
      n_tests++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, required %h", k_name(c.kind), got, c.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge cpu_clk);
      #1;
    end
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input logic [31:0] aux = 32'h0);
    chk_t c;
    c.kind = kind; c.exp = exp; c.aux = aux;
    chks.push_back(c);
  endtask

  task automatic access(input logic [31:0] a, input bit st, input logic [31:0] wv);
    logic [31:0] rv;
    rv = {<<{wv}};
    bus.data_out = a;
    bus.is_addr  = 1'b1;
    cyc(1);
    bus.is_addr  = 1'b0;
    bus.data_out = st ? rv : 32'($urandom());
    bus.is_data  = 1'b1;
    bus.is_store = st;
    cyc(1);
    bus.is_data  = 1'b0;
    bus.is_store = 1'b0;
    bus.data_out = 32'($urandom());
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input int tag);
    rd_t e;
    e.tag = tag; e.v = exp;
    exp_rd.push_back(e);
    access(a, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    access(a, 1'b1, v);
  endtask

  task automatic rd_data_model();
    logic [31:0] e;
    e = (rxq.size() != 0) ? 32'(rxq.pop_front()) : 32'h0;
    rd(A_UDATA, e, 1);
  endtask

  task automatic inject(input logic [7:0] b);
    bit to;
    to = 1'b1;
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (uart_rx_read) begin
        to = 1'b0;
        break;
      end
    end
    uart_rx_valid = 1'b0;
    exp_pulses++;
    if (rxq.size() < RXD) rxq.push_back(b);
    else m_ovf = 1'b1;
    chk(K_TMO, 32'h0, 32'(to));
    cyc(1);
  endtask

  // RX byte arrives in the same cycle as the CPU data phase (read or status store)
  task automatic rx_with_access(input logic [31:0] a, input bit st, input logic [31:0] wv, input logic [7:0] b);
    logic [31:0] rv;
    rv = {<<{wv}};
    bus.data_out = a;
    bus.is_addr  = 1'b1;
    cyc(1);
    bus.is_addr   = 1'b0;
    bus.data_out  = st ? rv : 32'($urandom());
    bus.is_data   = 1'b1;
    bus.is_store  = st;
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    cyc(1);
    bus.is_data   = 1'b0;
    bus.is_store  = 1'b0;
    uart_rx_valid = 1'b0;
    exp_pulses++;
    cyc(1);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    bit          to;
    rd_t         e;
    bus.data_out = '0; bus.is_addr = 1'b0; bus.is_data = 1'b0; bus.is_store = 1'b0;
    gpio_in = 3'b000; tx_stall = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    m_ovf = 1'b0; m_drop = 1'b0; m_idle = 1'b1; m_txlvl = 0; m_gpio = '0; exp_pulses = 0;

    // Reset state
    rstn = 1'b0;
    cyc(3);
    chk(K_GPIO, 32'h0);
    chk(K_TXEN, 32'h0);
    chk(K_RXRD, 32'h0);
    chk(K_TXDATA, 32'h0);
    cyc(1);
    rstn = 1'b1;
    cyc(1);
    rd(A_USTAT, stat_word(), 2);

    // GPIO write/read
    wr(A_GPIO, 32'h0000_0001);
    m_gpio = 32'h1;
    chk(K_GPIO, m_gpio);
    gpio_in = 3'b101;
    rd(A_GPIO, 32'h5, 0);

    // TX fill to full while the line is busy, then overflow by one
    tx_stall = 1'b1;
    m_idle   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = 8'h41 + 8'(i);
      wr(A_UDATA, 32'(b));
      exp_tx.push_back(b);
      m_txlvl++;
    end
    rd(A_USTAT, stat_word(), 2);
    wr(A_UDATA, 32'h49);
    m_drop = 1'b1;
    rd(A_USTAT, stat_word(), 2);
    tx_stall = 1'b0;
    cyc(8 * (FRAME + 6));
    m_txlvl = 0;
    m_idle  = 1'b1;
    chk(K_TXLEFT, 32'h0);
    rd(A_USTAT, stat_word(), 2);

    // RX: nine bytes with no CPU reads
    for (int i = 1; i <= 9; i++) inject(8'(i));
    chk(K_PULSES, 32'(exp_pulses));
    rd(A_USTAT, stat_word(), 2);

    // Clear both sticky flags
    wr(A_USTAT, 32'h0000_000C);
    m_ovf = 1'b0; m_drop = 1'b0;
    rd(A_USTAT, stat_word(), 2);

    // Full RX FIFO: push and CPU pop in the same cycle
    b = 8'($urandom());
    e.tag = 1; e.v = 32'(rxq.pop_front());
    exp_rd.push_back(e);
    rxq.push_back(b);
    rx_with_access(A_UDATA, 1'b0, 32'h0, b);
    rd(A_USTAT, stat_word(), 2);

    // Drain all and one extra read of the empty FIFO
    for (int i = 0; i < 9; i++) rd_data_model();
    rd(A_USTAT, stat_word(), 2);

    // Refill, then clear coincident with a new overflow: set wins
    for (int i = 0; i < 8; i++) inject(8'($urandom()));
    m_ovf = 1'b1;
    m_drop = 1'b0;
    rx_with_access(A_USTAT, 1'b1, 32'h0000_000C, 8'($urandom()));
    chk(K_PULSES, 32'(exp_pulses));
    rd(A_USTAT, stat_word(), 2);
    for (int i = 0; i < 8; i++) rd_data_model();

    // Reset while the drain FSM waits for the frame to end with 3 bytes queued
    v = 32'($urandom()) | 32'h1;
    wr(A_GPIO, v);
    m_gpio = v;
    chk(K_GPIO, m_gpio);
    tx_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom());
      wr(A_UDATA, 32'(b));
      if (i == 0) exp_tx.push_back(b);
    end
    tx_stall = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (tx_frame_busy) begin
        to = 1'b0;
        break;
      end
    end
    chk(K_TMO, 32'h0, 32'(to));
    cyc(2);
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    rxq.delete();
    m_ovf = 1'b0; m_drop = 1'b0; m_txlvl = 0; m_idle = 1'b1; m_gpio = '0;
    chk(K_GPIO, 32'h0);
    rd(A_USTAT, stat_word(), 2);
    chk(K_TXLEFT, 32'h0);

    // Randomized operation mix
    repeat (80) begin
      case ($urandom_range(0, 6))
        0: inject(8'($urandom()));
        1: rd_data_model();
        2: rd(A_USTAT, stat_word(), 2);
        3: begin
          v = 32'($urandom());
          wr(A_GPIO, v);
          m_gpio = v;
          chk(K_GPIO, m_gpio);
          gpio_in = 3'($urandom());
          rd(A_GPIO, {29'h0, gpio_in}, 0);
        end
        4: begin
          v = 32'($urandom());
          wr(A_USTAT, v);
          if (v[2]) m_ovf = 1'b0;
          if (v[3]) m_drop = 1'b0;
          rd(A_USTAT, stat_word(), 2);
        end
        5: begin
          v = A_GPIO | (32'($urandom_range(1, 255)) << 2);
          rd(v, 32'h0, 3);
          wr(v, 32'($urandom()));
          chk(K_GPIO, m_gpio);
        end
        default: begin
          b = 8'($urandom());
          wr(A_UDATA, 32'(b));
          exp_tx.push_back(b);
          cyc(FRAME + 10);
          chk(K_TXLEFT, 32'h0);
        end
      endcase
    end

    cyc(FRAME + 10);
    chk(K_TXLEFT, 32'h0);
    chk(K_PULSES, 32'(exp_pulses));
    rd(A_USTAT, stat_word(), 2);
    cyc(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
